// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the single-byte I2C master.
//   - FSM state encoding (4-bit localparams)
//   - quarter-period indices Q0..Q3 within one SCL bit period
//   - R/W bit values and ACK/NACK line levels
package i2c_pkg;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_START     = 4'd1;
   localparam logic [3:0] ST_ADDR      = 4'd2;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd3;
   localparam logic [3:0] ST_WRITE     = 4'd4;
   localparam logic [3:0] ST_WRITE_ACK = 4'd5;
   localparam logic [3:0] ST_READ      = 4'd6;
   localparam logic [3:0] ST_READ_NACK = 4'd7;
   localparam logic [3:0] ST_STOP      = 4'd8;
   localparam logic [3:0] ST_DONE      = 4'd9;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen: divides clk into SCL quarter-period ticks.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   restart  in   clears the divider and quarter index (transaction accept)
//   hold     in   keeps the quarter index where it is on a tick
//   tick     out  one-clk pulse every CLK_DIV clocks
//   quarter  out  current quarter (Q0..Q3); advances on each tick
module i2c_clk_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   input  logic       hold,
   output logic       tick,
   output logic [1:0] quarter
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [1:0]    quarter_q;

   // The accept edge itself is never a tick, so the first quarter lasts a
   // full CLK_DIV clocks.
   assign tick    = !restart && (cnt_q == CW'(CLK_DIV - 1));
   assign quarter = quarter_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         quarter_q <= Q0;
      end else if (restart) begin
         cnt_q     <= '0;
         quarter_q <= Q0;
      end else if (tick) begin
         cnt_q <= '0;
         if (!hold) begin
            quarter_q <= quarter_q + 2'd1;
         end
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master (START, addr+R/W, one data byte,
// ACK handling, STOP). SCL period is 4*CLK_DIV clk (CLK_DIV >= 1).
// Ports:
//   clk, rst          system clock / asynchronous active-high reset
//   start             transaction request, sampled only while idle
//   addr, rw, data_wr target address, direction, write byte (captured on accept)
//   data_rd           last byte read from the bus
//   busy              high from the clock after accept until done
//   done              one-clk pulse at end of transaction (busy falls with it)
//   ack_err           address NACK seen in the last transaction
//   sda, scl          open-drain bus lines, drive 0 or Z only
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] data_wr,
   output logic [7:0] data_rd,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   inout  logic       sda,
   inout  logic       scl
);

   logic [3:0] state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] addr_byte_q, addr_byte_d;   // {addr, rw}
   logic [7:0] data_q, data_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] data_rd_q, data_rd_d;
   logic       ack_bit_q, ack_bit_d;
   logic       sda_oe_q, sda_oe_d;          // 1 = pull SDA low
   logic       scl_oe_q, scl_oe_d;          // 1 = pull SCL low
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ack_err_q, ack_err_d;

   logic       tick;
   logic [1:0] quarter;
   logic       accept;
   logic       bus_busy;
   logic       hold;

   assign accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign bus_busy = !sda || !scl;
   // Someone else owns the bus: park in START q1 until both lines float high.
   assign hold     = (state_q == ST_START) && (quarter == Q1) && bus_busy;

   i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .restart (accept),
      .hold    (hold),
      .tick    (tick),
      .quarter (quarter)
   );

   assign sda     = sda_oe_q ? 1'b0 : 1'bz;
   assign scl     = scl_oe_q ? 1'b0 : 1'bz;
   assign data_rd = data_rd_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;

   // Actions are keyed on the quarter being left: a tick in quarter N
   // performs the entry action of quarter N+1.
   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      addr_byte_d = addr_byte_q;
      data_d      = data_q;
      rx_d        = rx_q;
      data_rd_d   = data_rd_q;
      ack_bit_d   = ack_bit_q;
      sda_oe_d    = sda_oe_q;
      scl_oe_d    = scl_oe_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ack_err_d   = ack_err_q;

      if (accept) begin
         state_d     = ST_START;
         bit_d       = 3'd7;
         addr_byte_d = {addr, rw};
         data_d      = data_wr;
         busy_d      = 1'b1;
         ack_err_d   = 1'b0;
         sda_oe_d    = 1'b0;
         scl_oe_d    = 1'b0;
      end else if (state_q == ST_DONE) begin
         state_d = ST_IDLE;
      end else if (tick && busy_q) begin
         case (quarter)
            Q0: begin
               if (state_q == ST_STOP) scl_oe_d = 1'b0;
            end
            Q1: begin
               if (state_q == ST_START) begin
                  if (!bus_busy) sda_oe_d = 1'b1;      // START: SDA falls, SCL high
               end else if (state_q != ST_STOP) begin
                  scl_oe_d = 1'b0;
               end
            end
            Q2: begin
               case (state_q)
                  ST_START:    scl_oe_d  = 1'b1;
                  ST_STOP:     sda_oe_d  = 1'b0;          // STOP: SDA rises, SCL high
                  ST_ADDR_ACK: ack_bit_d = sda;
                  ST_READ:     rx_d      = {rx_q[6:0], sda};
                  default:     ;
               endcase
            end
            default: begin // Q3: end of bit period
               if (((state_q == ST_ADDR) || (state_q == ST_WRITE) || (state_q == ST_READ))
                   && (bit_q != 3'd0)) begin
                  bit_d = bit_q - 3'd1;
               end else begin
                  bit_d = 3'd7;
                  case (state_q)
                     ST_START:     state_d = ST_ADDR;
                     ST_ADDR:      state_d = ST_ADDR_ACK;
                     ST_ADDR_ACK: begin
                        if (ack_bit_q == NACK) begin
                           ack_err_d = 1'b1;
                           state_d   = ST_STOP;
                        end else begin
                           state_d = (addr_byte_q[0] == RW_WRITE) ? ST_WRITE : ST_READ;
                        end
                     end
                     ST_WRITE:     state_d = ST_WRITE_ACK;
                     ST_WRITE_ACK: state_d = ST_STOP;
                     ST_READ: begin
                        state_d = ST_READ_NACK;
                        if (addr_byte_q[0] == RW_READ) data_rd_d = rx_q;
                     end
                     ST_READ_NACK: state_d = ST_STOP;
                     ST_STOP: begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end
                     default:      state_d = ST_IDLE;
                  endcase
               end

               // Entry to q0 of the next bit: SCL low, present SDA.
               scl_oe_d = 1'b1;
               case (state_d)
                  ST_ADDR:  sda_oe_d = ~addr_byte_q[bit_d];
                  ST_WRITE: sda_oe_d = ~data_q[bit_d];
                  ST_STOP:  sda_oe_d = 1'b1;
                  ST_DONE: begin
                     scl_oe_d = 1'b0;
                     sda_oe_d = 1'b0;
                  end
                  default:  sda_oe_d = 1'b0;    // ACK slots and READ: released
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_q       <= 3'd7;
         addr_byte_q <= 8'h00;
         data_q      <= 8'h00;
         rx_q        <= 8'h00;
         data_rd_q   <= 8'h00;
         ack_bit_q   <= ACK;
         sda_oe_q    <= 1'b0;
         scl_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ack_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         addr_byte_q <= addr_byte_d;
         data_q      <= data_d;
         rx_q        <= rx_d;
         data_rd_q   <= data_rd_d;
         ack_bit_q   <= ack_bit_d;
         sda_oe_q    <= sda_oe_d;
         scl_oe_q    <= scl_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ack_err_q   <= ack_err_d;
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master. Two masters (CLK_DIV=4 and
// CLK_DIV=1) share one pulled-up bus with a behavioural slave at 7'h50.
`timescale 1ns/1ps
module tb_i2c_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;          // 0 = dut4 active, 1 = dut1 active
   logic       start_r = 1'b0;
   logic [6:0] addr = 7'h00;
   logic       rw = 1'b0;
   logic [7:0] data_wr = 8'h00;

   logic [7:0] data_rd4, data_rd1;
   logic       busy4, busy1, done4, done1, ack_err4, ack_err1;
   logic       start4, start1;
   logic [7:0] data_rd_m;
   logic       busy_m, done_m, ack_err_m;

   wire sda;
   wire scl;
   pullup (sda);
   pullup (scl);

   logic slv_oe = 1'b0;
   assign sda = slv_oe ? 1'b0 : 1'bz;

   assign start4    = start_r & ~sel;
   assign start1    = start_r & sel;
   assign data_rd_m = sel ? data_rd1 : data_rd4;
   assign busy_m    = sel ? busy1 : busy4;
   assign done_m    = sel ? done1 : done4;
   assign ack_err_m = sel ? ack_err1 : ack_err4;

   i2c_master #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .addr(addr), .rw(rw), .data_wr(data_wr),
      .data_rd(data_rd4), .busy(busy4), .done(done4), .ack_err(ack_err4),
      .sda(sda), .scl(scl)
   );

   i2c_master #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .addr(addr), .rw(rw), .data_wr(data_wr),
      .data_rd(data_rd1), .busy(busy1), .done(done1), .ack_err(ack_err1),
      .sda(sda), .scl(scl)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural slave + bus monitor (samples on negedge) ----------------
   localparam logic [6:0] SLV_ADDR = 7'h50;
   logic [7:0] slv_data_out = 8'hCC;
   logic [7:0] slv_data_in  = 8'h00;
   logic [7:0] sh = 8'h00;
   logic       matched = 1'b0;
   logic       slv_rw = 1'b0;
   logic       master_ack_bit = 1'b0;
   logic       sda_p = 1'b1, scl_p = 1'b1;
   int         n_rise = 0, last_rises = 0, n_start = 0, n_stop = 0;

   initial begin
      logic s, c;
      forever begin
         @(negedge clk);
         s = sda;
         c = scl;
         if (scl_p && c && sda_p && !s) begin            // START
            n_start++;
            n_rise  = 0;
            matched = 1'b0;
            slv_oe  = 1'b0;
         end else if (scl_p && c && !sda_p && s) begin   // STOP
            n_stop++;
            last_rises = n_rise;
            matched = 1'b0;
            slv_oe  = 1'b0;
         end else if (!scl_p && c) begin                 // SCL rising
            n_rise++;
            if (n_rise <= 8) sh = {sh[6:0], s};
            if (n_rise == 8) begin
               matched = (sh[7:1] == SLV_ADDR);
               slv_rw  = sh[0];
            end
            if (matched && !slv_rw && n_rise >= 10 && n_rise <= 17) begin
               sh = {sh[6:0], s};
               if (n_rise == 17) slv_data_in = sh;
            end
            if (matched && slv_rw && n_rise == 18) master_ack_bit = s;
         end else if (scl_p && !c) begin                 // SCL falling
            slv_oe = 1'b0;
            if (matched) begin
               if (n_rise == 8) slv_oe = 1'b1;
               else if (slv_rw && n_rise >= 9 && n_rise <= 16) slv_oe = !slv_data_out[16 - n_rise];
               else if (!slv_rw && n_rise == 17) slv_oe = 1'b1;
            end
         end
         sda_p = s;
         scl_p = c;
      end
   end

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int failures = 0;
   int lat, n_done;
   logic ae_done, ae_accept, busy_accept, busy_done;

   // Runs one transaction on the selected master; start is re-pulsed at
   // cycles pa/pb after accept (use -1 for none).
   task automatic run_txn(input logic use1, input logic [6:0] a, input logic r,
                          input logic [7:0] d, input int pa, input int pb);
      sel = use1; addr = a; rw = r; data_wr = d;
      start_r = 1'b1;
      @(posedge clk); #1;              // accept edge
      start_r = 1'b0;
      busy_accept = busy_m;
      ae_accept   = ack_err_m;
      lat = -1; n_done = 0; ae_done = 1'b0; busy_done = 1'b1;
      for (int i = 1; i <= 2000; i++) begin
         start_r = (i == pa) || (i == pb);
         @(posedge clk); #1;
         if (done_m) begin
            n_done++;
            if (lat < 0) begin
               lat = i; ae_done = ack_err_m; busy_done = busy_m;
            end
         end
         if (lat >= 0 && i >= lat + 20) break;
      end
      start_r = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy4); end
      checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done4); end
      checks++; if (ack_err4 !== 1'b0) begin failures++; $display("FAIL reset_ack_err: got %b expected 0", ack_err4); end
      checks++; if (data_rd4 !== 8'h00) begin failures++; $display("FAIL reset_data_rd: got %h expected 00", data_rd4); end
      checks++; if (sda !== 1'b1 || scl !== 1'b1) begin failures++; $display("FAIL reset_bus: got sda=%b scl=%b expected 1 1", sda, scl); end
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      $display("test_reset: busy=%b done=%b data_rd=%h", busy4, done4, data_rd4);
   endtask

   task automatic test_write();
      int s0, p0;
      s0 = n_start; p0 = n_stop;
      run_txn(1'b0, 7'h50, 1'b0, 8'hA5, -1, -1);
      $display("test_write: lat=%0d ack_err=%b slave_in=%h", lat, ae_done, slv_data_in);
      checks++; if (busy_accept !== 1'b1) begin failures++; $display("FAIL write_busy_accept: got %b expected 1", busy_accept); end
      checks++; if (lat != 320) begin failures++; $display("FAIL write_latency: got %0d expected 320", lat); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL write_done_count: got %0d expected 1", n_done); end
      checks++; if (busy_done !== 1'b0) begin failures++; $display("FAIL write_busy_at_done: got %b expected 0", busy_done); end
      checks++; if (ae_done !== 1'b0) begin failures++; $display("FAIL write_ack_err: got %b expected 0", ae_done); end
      checks++; if (slv_data_in !== 8'hA5) begin failures++; $display("FAIL write_slave_data: got %h expected a5", slv_data_in); end
      checks++; if (data_rd_m !== 8'h00) begin failures++; $display("FAIL write_data_rd_hold: got %h expected 00", data_rd_m); end
      checks++; if (n_start - s0 != 1 || n_stop - p0 != 1) begin failures++; $display("FAIL write_start_stop: got %0d/%0d expected 1/1", n_start - s0, n_stop - p0); end
      // 18 bit clocks plus the SCL release that precedes STOP
      checks++; if (last_rises != 19) begin failures++; $display("FAIL write_scl_rises: got %0d expected 19", last_rises); end
   endtask

   task automatic test_read();
      int p0;
      p0 = n_stop;
      master_ack_bit = 1'b0;
      run_txn(1'b0, 7'h50, 1'b1, 8'h00, -1, -1);
      $display("test_read: lat=%0d ack_err=%b data_rd=%h", lat, ae_done, data_rd_m);
      checks++; if (data_rd_m !== 8'hCC) begin failures++; $display("FAIL read_data: got %h expected cc", data_rd_m); end
      checks++; if (ae_done !== 1'b0) begin failures++; $display("FAIL read_ack_err: got %b expected 0", ae_done); end
      checks++; if (master_ack_bit !== 1'b1) begin failures++; $display("FAIL read_master_nack: got %b expected 1", master_ack_bit); end
      checks++; if (n_stop - p0 != 1) begin failures++; $display("FAIL read_stop: got %0d expected 1", n_stop - p0); end
      checks++; if (lat != 320) begin failures++; $display("FAIL read_latency: got %0d expected 320", lat); end
   endtask

   task automatic test_nack();
      int p0;
      p0 = n_stop;
      run_txn(1'b0, 7'h51, 1'b0, 8'h5A, -1, -1);
      $display("test_nack: lat=%0d ack_err=%b rises=%0d", lat, ae_done, last_rises);
      checks++; if (ae_done !== 1'b1) begin failures++; $display("FAIL nack_ack_err: got %b expected 1", ae_done); end
      checks++; if (lat != 176) begin failures++; $display("FAIL nack_latency: got %0d expected 176", lat); end
      // 9 bit clocks plus the SCL release that precedes STOP
      checks++; if (last_rises != 10) begin failures++; $display("FAIL nack_scl_rises: got %0d expected 10", last_rises); end
      checks++; if (n_stop - p0 != 1) begin failures++; $display("FAIL nack_stop: got %0d expected 1", n_stop - p0); end
      checks++; if (data_rd_m !== 8'hCC) begin failures++; $display("FAIL nack_data_rd_hold: got %h expected cc", data_rd_m); end
      checks++; if (slv_data_in !== 8'hA5) begin failures++; $display("FAIL nack_slave_untouched: got %h expected a5", slv_data_in); end
   endtask

   task automatic test_back_to_back();
      run_txn(1'b0, 7'h50, 1'b0, 8'h96, 10, 100);
      $display("test_back_to_back: lat=%0d dones=%0d ack_err_accept=%b slave_in=%h", lat, n_done, ae_accept, slv_data_in);
      checks++; if (ae_accept !== 1'b0) begin failures++; $display("FAIL b2b_ack_err_clear: got %b expected 0", ae_accept); end
      checks++; if (lat != 320) begin failures++; $display("FAIL b2b_latency: got %0d expected 320", lat); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL b2b_done_count: got %0d expected 1", n_done); end
      checks++; if (slv_data_in !== 8'h96) begin failures++; $display("FAIL b2b_slave_data: got %h expected 96", slv_data_in); end
   endtask

   task automatic test_reset_mid();
      int s0, dones;
      sel = 1'b0; addr = 7'h50; rw = 1'b0; data_wr = 8'h5A;
      start_r = 1'b1;
      @(posedge clk); #1;
      start_r = 1'b0;
      repeat (65) @(posedge clk);
      #1;
      // q0 of the 4th address bit (a value of 0): both lines pulled low
      checks++; if (sda !== 1'b0 || scl !== 1'b0) begin failures++; $display("FAIL midrst_pre_bus: got sda=%b scl=%b expected 0 0", sda, scl); end
      rst = 1'b1;
      #1;
      checks++; if (sda !== 1'b1 || scl !== 1'b1) begin failures++; $display("FAIL midrst_bus_release: got sda=%b scl=%b expected 1 1", sda, scl); end
      checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy4); end
      checks++; if (data_rd4 !== 8'h00) begin failures++; $display("FAIL midrst_data_rd: got %h expected 00", data_rd4); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (done4) dones++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
      s0 = n_start;
      run_txn(1'b0, 7'h50, 1'b0, 8'h3C, -1, -1);
      $display("test_reset_mid: lat=%0d ack_err=%b slave_in=%h", lat, ae_done, slv_data_in);
      checks++; if (n_start - s0 != 1) begin failures++; $display("FAIL midrst_new_start: got %0d expected 1", n_start - s0); end
      checks++; if (ae_done !== 1'b0) begin failures++; $display("FAIL midrst_ack_err: got %b expected 0", ae_done); end
      checks++; if (slv_data_in !== 8'h3C) begin failures++; $display("FAIL midrst_slave_data: got %h expected 3c", slv_data_in); end
      checks++; if (lat != 320) begin failures++; $display("FAIL midrst_latency: got %0d expected 320", lat); end
   endtask

   task automatic test_div1();
      int s0, p0;
      s0 = n_start; p0 = n_stop;
      run_txn(1'b1, 7'h50, 1'b0, 8'hFF, -1, -1);
      $display("test_div1: lat=%0d ack_err=%b slave_in=%h rises=%0d", lat, ae_done, slv_data_in, last_rises);
      checks++; if (lat != 80) begin failures++; $display("FAIL div1_latency: got %0d expected 80", lat); end
      checks++; if (ae_done !== 1'b0) begin failures++; $display("FAIL div1_ack_err: got %b expected 0", ae_done); end
      checks++; if (slv_data_in !== 8'hFF) begin failures++; $display("FAIL div1_slave_data: got %h expected ff", slv_data_in); end
      checks++; if (n_start - s0 != 1 || n_stop - p0 != 1) begin failures++; $display("FAIL div1_start_stop: got %0d/%0d expected 1/1", n_start - s0, n_stop - p0); end
      checks++; if (last_rises != 19) begin failures++; $display("FAIL div1_scl_rises: got %0d expected 19", last_rises); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_back_to_back();
      test_reset_mid();
      test_div1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
